// File: rtl/aes_sys_pkg.sv
// Shared types and constants for the AES RAM block sequencer.
package aes_sys_pkg;

    localparam int DEF_ADDR_W = 12;   // 4096-byte staging RAM
    localparam int BLK_BYTES  = 16;   // bytes per AES block
    localparam int BLK_W      = 128;  // AES block width in bits
    localparam int IDX_W      = 4;    // byte index within a block

    typedef enum logic [2:0] {
        IDLE,
        RD,
        PRESENT,
        WAIT_RES,
        WR,
        NEXT,
        DONE
    } seq_state_e;

endpackage

// File: rtl/aes_byte_packer.sv
// Byte packer: gathers RAM read bytes into a 128-bit block (byte 0 in the MSB
// lane), holds the AES result for write-back and selects the byte being written.
module aes_byte_packer
    import aes_sys_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_vld,
    input  logic [IDX_W-1:0] issue_idx,
    input  logic [7:0]       ram_dout,
    input  logic             load,
    input  logic [BLK_W-1:0] load_data,
    input  logic [IDX_W-1:0] sel_idx,
    output logic [BLK_W-1:0] blk_data,
    output logic [7:0]       sel_byte
);

    logic [RD_LAT-1:0]            cap_vld_q, cap_vld_d;
    logic [RD_LAT-1:0][IDX_W-1:0] cap_idx_q, cap_idx_d;
    logic [BLK_W-1:0]             slot_q, slot_d;

    // Delay every issued read by RD_LAT cycles so its capture lines up with ram_dout.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        cap_vld_d    = cap_vld_q;
        cap_idx_d    = cap_idx_q;
        cap_vld_d[0] = issue_vld;
        cap_idx_d[0] = issue_idx;
        for (int i = 1; i < RD_LAT; i++) begin
            cap_vld_d[i] = cap_vld_q[i-1];
            cap_idx_d[i] = cap_idx_q[i-1];
        end
    end

    // Slot register: write a captured byte into its lane, or load the whole AES result.
    always_comb begin
        slot_d = slot_q;
        if (load) begin
            slot_d = load_data;
        end else if (cap_vld_q[RD_LAT-1]) begin
            for (int k = 0; k < BLK_BYTES; k++) begin
                if (cap_idx_q[RD_LAT-1] == IDX_W'(k)) begin
                    slot_d[BLK_W-1-8*k -: 8] = ram_dout;
                end
            end
        end
    end

    // Pick result byte sel_idx for the write-back data bus.
    always_comb begin
        sel_byte = 8'h00;
        for (int k = 0; k < BLK_BYTES; k++) begin
            if (sel_idx == IDX_W'(k)) begin
                sel_byte = slot_q[BLK_W-1-8*k -: 8];
            end
        end
    end

    // Capture pipeline and slot register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_vld_q <= '0;
            cap_idx_q <= '0;
            // NOTE: the slot store is reset on purpose: it drives blk_out_data directly,
            // which must read 0 out of reset; a pure datapath store would skip this.
            slot_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so all flops update together at the edge.
            cap_vld_q <= cap_vld_d;
            cap_idx_q <= cap_idx_d;
            slot_q    <= slot_d;
        end
    end

    assign blk_data = slot_q;

endmodule

// File: rtl/aes_ram_block_sequencer.sv
// AES RAM block sequencer: streams 16-byte blocks from the byte RAM to the AES
// core and writes each result back in place, for num_blocks consecutive blocks.
module aes_ram_block_sequencer
    import aes_sys_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int RD_LAT = 1,
    parameter int NBLK_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [NBLK_W-1:0] num_blocks,
    output logic              busy,
    output logic              done,
    output logic              ram_ce,
    output logic              ram_oce,
    output logic              ram_wre,
    output logic [ADDR_W-1:0] ram_ad,
    output logic [7:0]        ram_din,
    input  logic [7:0]        ram_dout,
    output logic [BLK_W-1:0]  blk_out_data,
    output logic              blk_out_valid,
    input  logic              blk_out_ready,
    input  logic [BLK_W-1:0]  blk_in_data,
    input  logic              blk_in_valid,
    output logic              blk_in_ready
);

    localparam int                CNT_W   = $clog2(BLK_BYTES + RD_LAT + 1);
    localparam logic [CNT_W-1:0]  RD_LAST = CNT_W'(BLK_BYTES + RD_LAT - 1);
    localparam logic [CNT_W-1:0]  WR_LAST = CNT_W'(BLK_BYTES - 1);
    localparam logic [CNT_W-1:0]  N_ISSUE = CNT_W'(BLK_BYTES);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [NBLK_W-1:0] nblk_q, nblk_d;
    logic [NBLK_W-1:0] blk_q, blk_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;

    logic              rd_issue;
    logic              res_load;
    logic [7:0]        wr_byte;
    logic [ADDR_W-1:0] byte_addr;

    // Address of byte cnt of block blk; wraps modulo 2^ADDR_W with no alignment.
    assign byte_addr = base_q + ADDR_W'({blk_q, {IDX_W{1'b0}}}) + ADDR_W'(cnt_q);

    aes_byte_packer #(
        .RD_LAT (RD_LAT)
    ) u_packer (
        .clk       (clk),
        .reset     (reset),
        .issue_vld (rd_issue),
        .issue_idx (cnt_q[IDX_W-1:0]),
        .ram_dout  (ram_dout),
        .load      (res_load),
        .load_data (blk_in_data),
        .sel_idx   (cnt_q[IDX_W-1:0]),
        .blk_data  (blk_out_data),
        .sel_byte  (wr_byte)
    );

    // Next-state, counters and all RAM / handshake outputs.
    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        nblk_d        = nblk_q;
        blk_d         = blk_q;
        cnt_d         = cnt_q;
        done_d        = 1'b0;
        busy          = 1'b0;
        ram_ce        = 1'b0;
        ram_wre       = 1'b0;
        ram_ad        = '0;
        ram_din       = 8'h00;
        blk_out_valid = 1'b0;
        blk_in_ready  = 1'b0;
        rd_issue      = 1'b0;
        res_load      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_blocks != '0) begin
                        base_d  = base_addr;
                        nblk_d  = num_blocks;
                        blk_d   = '0;
                        cnt_d   = '0;
                        state_d = RD;
                    end else begin
                        // Empty job: report completion without ever going busy.
                        done_d = 1'b1;
                    end
                end
            end
            RD: begin
                busy  = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q < N_ISSUE) begin
                    ram_ce   = 1'b1;
                    ram_ad   = byte_addr;
                    rd_issue = 1'b1;
                end
                // Stay until the last capture has drained from the read pipeline.
                if (cnt_q == RD_LAST) begin
                    cnt_d   = '0;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                busy          = 1'b1;
                blk_out_valid = 1'b1;
                if (blk_out_ready) begin
                    state_d = WAIT_RES;
                end
            end
            WAIT_RES: begin
                busy         = 1'b1;
                blk_in_ready = 1'b1;
                if (blk_in_valid) begin
                    res_load = 1'b1;
                    state_d  = WR;
                end
            end
            WR: begin
                busy    = 1'b1;
                ram_ce  = 1'b1;
                ram_wre = 1'b1;
                ram_ad  = byte_addr;
                ram_din = wr_byte;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == WR_LAST) begin
                    cnt_d   = '0;
                    state_d = NEXT;
                end
            end
            NEXT: begin
                busy = 1'b1;
                if (blk_q == (nblk_q - NBLK_W'(1))) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    blk_d   = blk_q + NBLK_W'(1);
                    state_d = RD;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and job registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            base_q  <= '0;
            nblk_q  <= '0;
            blk_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            nblk_q  <= nblk_d;
            blk_q   <= blk_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign ram_oce = ram_ce;
    assign done    = done_q;

endmodule

// File: tb/tb_aes_ram_block_sequencer.sv
// Self-checking bench for aes_ram_block_sequencer: behavioural RAM and AES core,
// reference model built from byte addresses and block XOR masks.
module tb_aes_ram_block_sequencer;

    logic         clk;
    logic         reset;
    logic         start;
    logic [11:0]  base_addr;
    logic [8:0]   num_blocks;
    logic         busy;
    logic         done;
    logic         ram_ce;
    logic         ram_oce;
    logic         ram_wre;
    logic [11:0]  ram_ad;
    logic [7:0]   ram_din;
    logic [7:0]   ram_dout;
    logic [127:0] blk_out_data;
    logic         blk_out_valid;
    logic         blk_out_ready;
    logic [127:0] blk_in_data;
    logic         blk_in_valid;
    logic         blk_in_ready;

    aes_ram_block_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .base_addr     (base_addr),
        .num_blocks    (num_blocks),
        .busy          (busy),
        .done          (done),
        .ram_ce        (ram_ce),
        .ram_oce       (ram_oce),
        .ram_wre       (ram_wre),
        .ram_ad        (ram_ad),
        .ram_din       (ram_din),
        .ram_dout      (ram_dout),
        .blk_out_data  (blk_out_data),
        .blk_out_valid (blk_out_valid),
        .blk_out_ready (blk_out_ready),
        .blk_in_data   (blk_in_data),
        .blk_in_valid  (blk_in_valid),
        .blk_in_ready  (blk_in_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural RAM (1-cycle read latency) ----------------
    logic [7:0]  mem     [4096];
    logic [7:0]  ref_mem [4096];
    logic [20:0] acc_q   [$];   // {we, addr, wdata} per RAM access
    logic        bd_we;
    logic [11:0] bd_addr;
    logic [7:0]  bd_data;

    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (ram_ce && ram_oce) begin
            acc_q.push_back({ram_wre, ram_ad, ram_wre ? ram_din : 8'h00});
            if (ram_wre) mem[ram_ad] <= ram_din;
            else         ram_dout    <= mem[ram_ad];
        end
    end

    // ---------------- protocol monitors ----------------
    int           done_cnt, busy_cnt, ce_cnt, mon_err;
    logic         prev_vld;
    logic [127:0] prev_data;

    initial begin
        done_cnt = 0; busy_cnt = 0; ce_cnt = 0; mon_err = 0;
        prev_vld = 1'b0; prev_data = '0;
    end

    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
        if (ram_ce) ce_cnt <= ce_cnt + 1;
        // RAM must be idle while a block or result is being handed over.
        if ((blk_out_valid || blk_in_ready) && ram_ce) mon_err <= mon_err + 1;
        if (blk_out_valid && prev_vld && (blk_out_data != prev_data)) mon_err <= mon_err + 1;
        if (done && busy) mon_err <= mon_err + 1;
        if (ram_wre && !ram_ce) mon_err <= mon_err + 1;
        prev_vld  <= blk_out_valid;
        prev_data <= blk_out_data;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [127:0] exp_blk [$];
    logic [127:0] exp_res [$];
    logic [20:0]  exp_acc [$];
    logic [127:0] first_blk;

    // Block b, byte k lives at (base + 16*b + k) mod 4096; result = block ^ mask.
    task automatic build_expect(input logic [11:0] base, input int n, input logic [127:0] mask);
        exp_blk.delete(); exp_res.delete(); exp_acc.delete();
        for (int b = 0; b < n; b++) begin
            logic [127:0] blk;
            logic [127:0] res;
            int a;
            for (int k = 0; k < 16; k++) begin
                a = (int'(base) + 16 * b + k) % 4096;
                blk[127 - 8 * k -: 8] = ref_mem[a];
                exp_acc.push_back({1'b0, 12'(a), 8'h00});
            end
            res = blk ^ mask;
            for (int k = 0; k < 16; k++) begin
                a = (int'(base) + 16 * b + k) % 4096;
                ref_mem[a] = res[127 - 8 * k -: 8];
                exp_acc.push_back({1'b1, 12'(a), res[127 - 8 * k -: 8]});
            end
            exp_blk.push_back(blk);
            exp_res.push_back(res);
        end
    endtask

    function automatic int ram_diffs();
        int d = 0;
        for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) d++;
        return d;
    endfunction

    function automatic int count_writes(input int from);
        int w = 0;
        for (int i = from; i < acc_q.size(); i++) if (acc_q[i][20]) w++;
        return w;
    endfunction

    task automatic preload(input int lo, input int cnt, input bit seq);
        for (int i = 0; i < cnt; i++) begin
            @(negedge clk);
            bd_we   = 1'b1;
            bd_addr = 12'(lo + i);
            bd_data = seq ? 8'(i) : 8'($urandom);
            ref_mem[(lo + i) % 4096] = bd_data;
        end
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // ---------------- AES core model ----------------
    task automatic core_serve(input int n, input int rdy_dly, input int vld_dly, input bit always_rdy);
        for (int b = 0; b < n; b++) begin
            int cyc = 0;
            while (!blk_out_valid && cyc < 200) begin
                @(negedge clk);
                cyc++;
            end
            check("blk_out_valid_seen", blk_out_valid, 1);
            check("blk_out_data", blk_out_data, exp_blk[b]);
            if (b == 0) first_blk = blk_out_data;
            if (always_rdy) begin
                blk_in_data = exp_res[b];
                @(negedge clk);
                @(negedge clk);
            end else begin
                repeat (rdy_dly) @(negedge clk);
                blk_out_ready = 1'b1;
                @(negedge clk);
                blk_out_ready = 1'b0;
                repeat (vld_dly) @(negedge clk);
                blk_in_data  = exp_res[b];
                blk_in_valid = 1'b1;
                cyc = 0;
                while (!blk_in_ready && cyc < 200) begin
                    @(negedge clk);
                    cyc++;
                end
                check("blk_in_ready_seen", blk_in_ready, 1);
                @(negedge clk);
                blk_in_valid = 1'b0;
                blk_in_data  = {4{$urandom}};
            end
        end
    endtask

    // ---------------- one complete job ----------------
    task automatic run_job(input string tag, input logic [11:0] base, input int n,
                           input logic [127:0] mask, input int rdy_dly, input int vld_dly,
                           input bit always_rdy, input bit poke);
        int a0, d0, b0, e0, cyc;
        build_expect(base, n, mask);
        a0 = acc_q.size(); d0 = done_cnt; b0 = busy_cnt; e0 = mon_err;
        blk_out_ready = always_rdy;
        blk_in_valid  = always_rdy;
        @(negedge clk);
        start = 1'b1; base_addr = base; num_blocks = 9'(n);
        @(negedge clk);
        start = 1'b0; base_addr = 12'($urandom); num_blocks = 9'($urandom);
        fork
            core_serve(n, rdy_dly, vld_dly, always_rdy);
            begin
                if (poke) begin
                    repeat (6) @(negedge clk);
                    start = 1'b1; base_addr = 12'h000; num_blocks = 9'd7;
                    @(negedge clk);
                    start = 1'b0;
                end
            end
        join
        cyc = 0;
        while (done_cnt == d0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        repeat (3) @(negedge clk);
        blk_out_ready = 1'b0;
        blk_in_valid  = 1'b0;
        check({tag, "_done_pulses"}, done_cnt - d0, 1);
        if (always_rdy) check({tag, "_busy_cycles"}, busy_cnt - b0, 36 * n);
        check({tag, "_access_count"}, acc_q.size() - a0, exp_acc.size());
        for (int i = 0; i < exp_acc.size() && (a0 + i) < acc_q.size(); i++)
            check({tag, "_access"}, acc_q[a0 + i], exp_acc[i]);
        check({tag, "_protocol_errors"}, mon_err - e0, 0);
        check({tag, "_ram_image_diffs"}, ram_diffs(), 0);
        check({tag, "_busy_after"}, busy, 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [127:0] mask, blk, res;
        int d0, b0, c0, a0, e0, cyc;

        reset = 1'b1; start = 1'b0; base_addr = '0; num_blocks = '0;
        blk_out_ready = 1'b0; blk_in_valid = 1'b0; blk_in_data = '0;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        first_blk = '0;
        #1;
        check("rst_ctrl", {busy, done, ram_ce, ram_oce, ram_wre, blk_out_valid, blk_in_ready}, 0);
        check("rst_ram_ad", ram_ad, 0);
        check("rst_ram_din", ram_din, 0);
        check("rst_blk_out_data", blk_out_data, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle_ctrl", {busy, done, ram_ce}, 0);

        preload(0, 4096, 1'b0);

        // Single block, known contents, core inverts every byte.
        preload(12'h100, 16, 1'b1);
        run_job("single", 12'h100, 1, {16{8'hFF}}, 0, 0, 1'b1, 1'b0);
        check("single_block_value", first_blk, 128'h000102030405060708090a0b0c0d0e0f);
        check("single_ram_first", mem[12'h100], 8'hFF);
        check("single_ram_last", mem[12'h10F], 8'hF0);

        // Address wrap at the top of the RAM.
        run_job("wrap", 12'hFF8, 1, {4{$urandom}}, 1, 2, 1'b0, 1'b0);

        // Long stalls on both handshakes.
        run_job("backpressure", 12'h2A3, 1, {4{$urandom}}, 20, 30, 1'b0, 1'b0);

        // Three consecutive blocks from address 0.
        run_job("multi", 12'h000, 3, {4{$urandom}}, 2, 1, 1'b0, 1'b0);

        // Empty job: done the next cycle, never busy, RAM untouched.
        d0 = done_cnt; b0 = busy_cnt; c0 = ce_cnt;
        @(negedge clk);
        start = 1'b1; base_addr = 12'h123; num_blocks = 9'd0;
        @(negedge clk);
        start = 1'b0;
        check("zero_done_next", done, 1);
        @(negedge clk);
        check("zero_done_single", done, 0);
        repeat (3) @(negedge clk);
        check("zero_done_count", done_cnt - d0, 1);
        check("zero_busy_cycles", busy_cnt - b0, 0);
        check("zero_ce_cycles", ce_cnt - c0, 0);

        // Start while busy is ignored.
        run_job("busy_start", 12'h5A0, 2, {4{$urandom}}, 2, 3, 1'b0, 1'b1);

        // Reset after 8 write-back cycles.
        mask = {4{$urandom}};
        for (int k = 0; k < 16; k++) blk[127 - 8 * k -: 8] = ref_mem[(12'h300 + k) % 4096];
        res = blk ^ mask;
        d0 = done_cnt; a0 = acc_q.size(); e0 = mon_err;
        blk_out_ready = 1'b1; blk_in_valid = 1'b1; blk_in_data = res;
        @(negedge clk);
        start = 1'b1; base_addr = 12'h300; num_blocks = 9'd1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (count_writes(a0) < 8 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        reset = 1'b1;
        #1;
        check("midwr_rst_ctrl", {busy, done, ram_ce, ram_oce, ram_wre, blk_out_valid, blk_in_ready}, 0);
        check("midwr_rst_ram_ad", ram_ad, 0);
        check("midwr_rst_ram_din", ram_din, 0);
        check("midwr_rst_blk_out_data", blk_out_data, 0);
        check("midwr_write_count", count_writes(a0), 8);
        for (int k = 0; k < 8; k++) ref_mem[12'h300 + k] = res[127 - 8 * k -: 8];
        blk_out_ready = 1'b0; blk_in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("midwr_no_done", done_cnt - d0, 0);
        check("midwr_ram_image_diffs", ram_diffs(), 0);
        check("midwr_protocol_errors", mon_err - e0, 0);
        run_job("after_reset", 12'h300, 1, {4{$urandom}}, 0, 0, 1'b1, 1'b0);

        // Randomized jobs.
        for (int j = 0; j < 5; j++) begin
            run_job("random", 12'($urandom), int'($urandom_range(1, 4)), {4{$urandom}},
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                    1'($urandom_range(0, 1)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_ram_block_sequencer.md
Name: aes_ram_block_sequencer

Overview:
- Sequences AES blocks between the 8-bit x 4K single-port byte RAM (software/UART staging buffer) and the 128-bit AES core.
- Per block: reads 16 consecutive bytes from RAM, packs them into a 128-bit block and hands it to the core (valid/ready); accepts the 128-bit result and writes it back in place over the same 16 bytes.
- Sits directly on the RAM's port as its sole master while busy.

Parameters:
- ADDR_W, 12, RAM byte-address width (4096 bytes).
- RD_LAT, 1, RAM read latency in clocks: address/ce edge to valid ram_dout.
- NBLK_W, 9, width of num_blocks (1..256 blocks).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  pulse; sampled only in IDLE.
- base_addr  in  ADDR_W  byte address of block 0; latched on accepted start.
- num_blocks  in  NBLK_W  blocks to process; latched on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the job ends.
- ram_ce  out  1  RAM clock enable.
- ram_oce  out  1  RAM output register enable; equals ram_ce.
- ram_wre  out  1  RAM write enable.
- ram_ad  out  ADDR_W  RAM byte address.
- ram_din  out  8  RAM write data.
- ram_dout  in  8  RAM read data.
- blk_out_data  out  128  plaintext/ciphertext block to the AES core.
- blk_out_valid  out  1  block offered to the core.
- blk_out_ready  in  1  core accepts the block.
- blk_in_data  in  128  result block from the AES core.
- blk_in_valid  in  1  result offered.
- blk_in_ready  out  1  sequencer accepts the result.

Behaviour:
- Reset (async, active-high): state IDLE. All outputs 0: busy, done, ram_ce, ram_oce, ram_wre, ram_ad, ram_din, blk_out_valid, blk_in_ready. blk_out_data is also 0; block counter and byte counter are cleared.
- A reset mid-job abandons the job without a done pulse. A partially written block remains partially written.
- Byte order:
  - Byte at address A+k (k = 0..15) maps to blk_out_data[127-8k -: 8], so byte 0 is the MSB (FIPS-197 order).
  - The write-back uses the same mapping from blk_in_data.
- Address of block b, byte k = base_addr + 16*b + k, modulo 2^ADDR_W. It wraps silently; no alignment is required.
- IDLE:
  - start=1 with num_blocks != 0: latch inputs and go to RD.
  - start=1 with num_blocks == 0: pulse done for 1 cycle and stay in IDLE; busy never rises.
- RD (16 + RD_LAT cycles):
  - Issue cycles k = 0..15: ram_ce=ram_oce=1, ram_wre=0, ram_ad = address of byte k.
  - Capture: ram_dout is stored into byte slot k exactly RD_LAT cycles after issue k.
  - After the last issue, ram_ce=0 while the remaining captures drain.
  - Then go to PRESENT.
- PRESENT:
  - blk_out_valid=1 with blk_out_data held stable.
  - Leave on blk_out_valid && blk_out_ready, and go to WAIT_RES.
- WAIT_RES:
  - blk_in_ready=1.
  - On blk_in_valid && blk_in_ready, latch blk_in_data and go to WR.
  - blk_in_valid is ignored in every other state.
- WR (16 cycles): ram_ce=ram_oce=ram_wre=1, ram_ad = address of byte k, ram_din = result byte k, for k = 0..15.
- NEXT (1 cycle): ram_ce=0.
  - If more blocks remain: increment the block counter and go to RD.
  - Otherwise go to DONE.
- DONE (1 cycle): done=1, then IDLE. busy falls in the same cycle done is high.
- start while busy is ignored, with no queueing. Inputs are not re-latched mid-job.
- ram_ce=0 in every cycle not listed above. ram_wre is never high outside WR.
- Single block timing with ready/valid both already high: 16+RD_LAT (RD) + 1 (PRESENT) + 1 (WAIT_RES) + 16 (WR) + 1 (NEXT) + 1 (DONE) cycles.

Decomposition:
- Shared package aes_sys_pkg holds:
  - state enum (IDLE, RD, PRESENT, WAIT_RES, WR, NEXT, DONE);
  - BLK_BYTES=16, BLK_W=128;
  - ADDR_W default.
- One natural sub-module, aes_byte_packer, containing:
  - the 16x8 shift/slot register;
  - the RD_LAT-deep capture-valid pipeline;
  - byte-k selection for write-back.
- The FSM and counters stay in the top.

Test Plan:
- Single block:
  - Setup: RAM[0x100..0x10F] = 00..0F; base_addr=0x100, num_blocks=1; core echoes result = block XOR {16{8'hFF}}.
  - Required: blk_out_data = 128'h000102...0F. RAM[0x100..0x10F] = FF..F0 afterwards. done pulses once. Exactly 16 reads then 16 writes are observed.
- Wrap-around:
  - Setup: base_addr=0xFF8, num_blocks=1.
  - Required: reads hit 0xFF8..0xFFF then 0x000..0x007. Write-back hits the same addresses. No access to 0x1000.
- Backpressure:
  - Setup: blk_out_ready held low 20 cycles; blk_in_valid delayed 30 cycles.
  - Required: blk_out_data stable while valid. No RAM access during the stall. Result written correctly.
- Multi-block:
  - Setup: base_addr=0x000, num_blocks=3.
  - Required: blocks at 0x000, 0x010, 0x020 processed in order. done pulses once, after the third write-back.
- Edge starts:
  - num_blocks=0: done pulses next cycle, busy stays 0, ram_ce stays 0.
  - start asserted while busy: ignored; the job completes with the original parameters.
- Reset mid-WR:
  - Stimulus: reset asserted after 8 write cycles.
  - Required: outputs 0 immediately. Bytes 0..7 updated, bytes 8..15 unchanged. No done pulse. A new start afterwards operates normally.
